// File: rtl/mult_sequencer.sv
// Sequencer for the EX-stage iterative multiplier: issues load, step and HI/LO
// write-back enables, and stalls dependent MULT/MFHI/MFLO while a multiply is in flight.
module mult_sequencer #(
  parameter int          MULT_CYCLES = 32,
  parameter logic [5:0]  F_MULT      = 6'b011001,
  parameter logic [5:0]  F_MFHI      = 6'b010000,
  parameter logic [5:0]  F_MFLO      = 6'b010010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic [1:0] ALUop,
  input  logic [5:0] Funct,
  input  logic       abort,
  output logic       mult_load,
  output logic       mult_step,
  output logic       hilo_we,
  output logic       stall,
  output logic       busy,
  output logic [5:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE} state_t;

  localparam logic [5:0] LAST_STEP = 6'(MULT_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] count_next;
  logic       is_rtype;
  logic       is_mult;
  logic       is_mfx;
  logic       is_dep;
  logic       accept;

  assign is_rtype = ex_valid & (ALUop == 2'b10);
  assign is_mult  = is_rtype & (Funct == F_MULT);
  assign is_mfx   = is_rtype & ((Funct == F_MFHI) | (Funct == F_MFLO));
  assign is_dep   = is_mult | is_mfx;
  assign accept   = (state == IDLE) & is_mult & ~abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 6'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // abort from any busy state drops straight back to IDLE and discards progress
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          count_next = 6'd0;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          count_next = 6'd0;
        end else if (count == LAST_STEP) begin
          state_next = WRITE;
          count_next = 6'd0;
        end else begin
          count_next = count + 6'd1;
        end
      end
      WRITE: begin
        state_next = IDLE;
        count_next = 6'd0;
      end
      default: begin
        state_next = IDLE;
        count_next = 6'd0;
      end
    endcase
  end

  always_comb begin
    mult_load = accept;
    mult_step = 1'b0;
    hilo_we   = 1'b0;
    busy      = (state != IDLE);
    stall     = is_dep & (state != IDLE);
    case (state)
      RUN:     mult_step = 1'b1;
      WRITE:   hilo_we   = ~abort;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: a time-since-accept reference model plus a
// bench-side shift-add multiplier that is driven by the DUT enables and feeds HI/LO.
module tb_mult_sequencer;

  localparam int         MC     = 32;
  localparam logic [5:0] F_MULT = 6'b011001;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_SRL  = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid = 1'b0;
  logic [1:0] ALUop = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic       abort = 1'b0;
  logic       mult_load, mult_step, hilo_we, stall, busy;
  logic [5:0] count;
  logic [10:0] obs;

  logic [31:0] data_a = 32'd0;
  logic [31:0] data_b = 32'd0;

  int total = 0;
  int bad = 0;

  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [63:0] pend = 64'd0;
  logic [63:0] exp_hilo = 64'd0;

  logic [31:0] ma, mb;
  logic [63:0] acc;
  logic [63:0] hilo = 64'd0;
  int          idx;

  mult_sequencer #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ALUop(ALUop), .Funct(Funct),
    .abort(abort), .mult_load(mult_load), .mult_step(mult_step), .hilo_we(hilo_we),
    .stall(stall), .busy(busy), .count(count)
  );

  assign obs = {mult_load, mult_step, hilo_we, stall, busy, count};

  always #5 clk = ~clk;

  // Stand-in datapath: one partial product per step, so a wrong step count corrupts HI/LO
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= 64'd0;
      idx <= 0;
    end else begin
      if (mult_load) begin
        ma  <= data_a;
        mb  <= data_b;
        acc <= 64'd0;
        idx <= 0;
      end else if (mult_step) begin
        if (idx < 32 && mb[idx]) acc <= acc + ({32'd0, ma} << idx);
        idx <= idx + 1;
      end
      if (hilo_we) hilo <= acc;
    end
  end

  // Expected outputs from elapsed cycles since the accepted MULT (m_k = 1 on the first busy cycle)
  function automatic logic [10:0] exp_out();
    logic is_r, is_m, is_f;
    logic [5:0] cnt;
    is_r = ex_valid && (ALUop == 2'b10);
    is_m = is_r && (Funct == F_MULT);
    is_f = is_r && (Funct == F_MFHI || Funct == F_MFLO);
    if (!m_active) return {is_m && !abort, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    cnt = (m_k <= MC) ? 6'(m_k - 1) : 6'd0;
    return {1'b0, m_k <= MC, (m_k == MC + 1) && !abort, is_m || is_f, 1'b1, cnt};
  endfunction

  task automatic model_advance();
    if (reset) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (abort || m_k == MC + 1) begin
        if (!abort) exp_hilo = pend;
        m_active = 1'b0;
      end else begin
        m_k++;
      end
    end else if (ex_valid && ALUop == 2'b10 && Funct == F_MULT && !abort) begin
      m_active = 1'b1;
      m_k = 1;
      pend = {32'd0, data_a} * {32'd0, data_b};
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic ab);
    ex_valid = v;
    ALUop = op;
    Funct = fn;
    abort = ab;
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 2'b00, 6'd0, 0);
    @(negedge clk);
    total++;
    if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
      bad++;
      $display("[TB] FAIL reset_init got=%h/%h want=%h/%h", obs, hilo, exp_out(), exp_hilo);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
    drive(1, 2'b10, F_MULT, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL reset_run k=%0d got=%h/%h want=%h/%h", m_k, obs, hilo, exp_out(), exp_hilo);
      end
      if (m_active && m_k == 11) break;
      tick();
      drive(1, 2'b10, F_MFLO, 0);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("[TB] FAIL reset_async got=%b want=%b", obs, 11'd0);
    end
    m_active = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
      bad++;
      $display("[TB] FAIL reset_release got=%h/%h want=%h/%h", obs, hilo, exp_out(), exp_hilo);
    end
    tick();
    data_a = $urandom;
    data_b = $urandom;
    drive(1, 2'b10, F_MULT, 0);
    for (int c = 0; c < MC + 4; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL reset_rerun k=%0d got=%h/%h want=%h/%h", m_k, obs, hilo, exp_out(), exp_hilo);
      end
      tick();
      drive(0, 2'b00, 6'd0, 0);
    end
  endtask

  task automatic test_single_mult();
    int pulses;
    pulses = 0;
    data_a = 32'd7;
    data_b = 32'd6;
    drive(1, 2'b10, F_MULT, 0);
    for (int c = 0; c < MC + 3; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL single c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      if (mult_step) pulses++;
      tick();
      drive(0, 2'b00, 6'd0, 0);
      data_a = $urandom;
      data_b = $urandom;
    end
    total++;
    if (pulses != MC) begin
      bad++;
      $display("[TB] FAIL single_steps got=%0d want=%0d", pulses, MC);
    end
    total++;
    if (hilo !== 64'd42) begin
      bad++;
      $display("[TB] FAIL single_hilo got=%h want=%h", hilo, 64'd42);
    end
  endtask

  task automatic test_mflo_stall();
    int stalled;
    bit released;
    stalled = 0;
    released = 1'b0;
    data_a = 32'd11;
    data_b = 32'd13;
    drive(1, 2'b10, F_MULT, 0);
    for (int c = 0; c < 60 && !released; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL mflo c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      if (c >= 5) begin
        if (stall) stalled++;
        else released = 1'b1;
      end
      if (released) begin
        total++;
        if (hilo !== 64'd143) begin
          bad++;
          $display("[TB] FAIL mflo_value got=%h want=%h", hilo, 64'd143);
        end
      end
      tick();
      if (c + 1 >= 5) drive(1, 2'b10, F_MFLO, 0);
      else drive(0, 2'b00, 6'd0, 0);
    end
    total++;
    if (!released || stalled != MC - 3) begin
      bad++;
      $display("[TB] FAIL mflo_window got=%0d/%0d want=%0d/1", stalled, released, MC - 3);
    end
    drive(0, 2'b00, 6'd0, 0);
  endtask

  task automatic test_add_while_busy();
    data_a = $urandom;
    data_b = $urandom;
    drive(1, 2'b10, F_MULT, 0);
    for (int c = 0; c < MC + 3; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL add_busy c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      tick();
      case ((c + 1) % 4)
        0: drive(1, 2'b00, 6'($urandom), 0);
        1: drive(1, 2'b10, F_AND, 0);
        2: drive(1, 2'b10, F_SRL, 0);
        default: drive(1, 2'b10, F_ADD, 0);
      endcase
    end
    drive(0, 2'b00, 6'd0, 0);
  endtask

  task automatic test_back_to_back();
    int wait_cycles;
    bit loaded;
    loaded = 1'b0;
    wait_cycles = 0;
    data_a = 32'hFFFF_FFFF;
    data_b = 32'd2;
    drive(1, 2'b10, F_MULT, 0);
    @(negedge clk);
    total++;
    if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
      bad++;
      $display("[TB] FAIL b2b_first got=%h/%h want=%h/%h", obs, hilo, exp_out(), exp_hilo);
    end
    tick();
    data_a = 32'd3;
    data_b = 32'd3;
    for (int c = 1; c < 100 && !loaded; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL b2b_hold c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      if (mult_load) begin
        loaded = 1'b1;
        wait_cycles = c;
        total++;
        if (hilo !== 64'h1_FFFF_FFFE) begin
          bad++;
          $display("[TB] FAIL b2b_first_hilo got=%h want=%h", hilo, 64'h1_FFFF_FFFE);
        end
      end
      tick();
    end
    total++;
    if (!loaded || wait_cycles != MC + 2) begin
      bad++;
      $display("[TB] FAIL b2b_accept got=%0d/%0d want=%0d/1", wait_cycles, loaded, MC + 2);
    end
    drive(0, 2'b00, 6'd0, 0);
    for (int c = 0; c < MC + 2; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL b2b_second c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      tick();
    end
    total++;
    if (hilo !== 64'd9) begin
      bad++;
      $display("[TB] FAIL b2b_hilo got=%h want=%h", hilo, 64'd9);
    end
  endtask

  task automatic test_abort();
    logic [63:0] prev;
    prev = hilo;
    for (int pass = 0; pass < 2; pass++) begin
      data_a = $urandom;
      data_b = $urandom;
      drive(1, 2'b10, F_MULT, 0);
      for (int c = 0; c < MC + 3; c++) begin
        // first pass aborts at count 20, second pass aborts in the write-back cycle
        if (m_active && m_k == ((pass == 0) ? 21 : MC + 1)) drive(0, 2'b00, 6'd0, 1);
        @(negedge clk);
        total++;
        if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
          bad++;
          $display("[TB] FAIL abort%0d c=%0d got=%h/%h want=%h/%h", pass, c, obs, hilo, exp_out(), exp_hilo);
        end
        tick();
        drive(0, 2'b00, 6'd0, 0);
      end
      total++;
      if (hilo !== prev) begin
        bad++;
        $display("[TB] FAIL abort%0d_hilo got=%h want=%h", pass, hilo, prev);
      end
    end
    drive(1, 2'b10, F_MULT, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL abort_idle c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      tick();
      drive(0, 2'b00, 6'd0, 0);
    end
  endtask

  task automatic test_random();
    logic [5:0] fns [6];
    fns = '{F_MULT, F_MFHI, F_MFLO, F_ADD, F_AND, F_SRL};
    for (int c = 0; c < 800; c++) begin
      data_a = $urandom;
      data_b = $urandom;
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b10,
            fns[$urandom_range(0, 5)], $urandom_range(0, 40) == 0);
      @(negedge clk);
      total++;
      if ({obs, hilo} !== {exp_out(), exp_hilo}) begin
        bad++;
        $display("[TB] FAIL random c=%0d got=%h/%h want=%h/%h", c, obs, hilo, exp_out(), exp_hilo);
      end
      tick();
    end
    drive(0, 2'b00, 6'd0, 0);
  endtask

  initial begin
    test_reset();
    test_single_mult();
    test_mflo_stall();
    test_add_while_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
